// File: rtl/text_ram_arbiter_if.sv
// text_ram_arbiter_if: request/ack and RAM write-port bundle for text_ram_arbiter.
// The arbiter takes the slave modport; requesters/bench take master.
//
// Handshake: a requester raises <x>_req together with a stable <x>_addr and
// <x>_data, and holds all three until it sees <x>_ack high for one cycle.
// The ack cycle is the cycle in which the RAM write happens, or in which the
// write is rejected with wr_err because the address is past the buffer.
// A requester may present its next word in the ack cycle itself. The arbiter
// ignores a request whose ack is currently high, so it samples that word at
// the following edge at the earliest.
interface text_ram_arbiter_if #(
   parameter int AW = 13,
   parameter int DW = 8
);
   logic          kb_req;
   logic [AW-1:0] kb_addr;
   logic [DW-1:0] kb_data;
   logic          kb_ack;
   logic          term_req;
   logic [AW-1:0] term_addr;
   logic [DW-1:0] term_data;
   logic          term_ack;
   logic          wr_err;
   logic          clr_start;
   logic          clr_busy;
   logic          clr_done;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;

   modport master (
      output kb_req, kb_addr, kb_data, term_req, term_addr, term_data, clr_start,
      input  kb_ack, term_ack, wr_err, clr_busy, clr_done, ram_we, ram_addr, ram_wdata
   );

   modport slave (
      input  kb_req, kb_addr, kb_data, term_req, term_addr, term_data, clr_start,
      output kb_ack, term_ack, wr_err, clr_busy, clr_done, ram_we, ram_addr, ram_wdata
   );
endinterface

// File: rtl/text_ram_arbiter.sv
// text_ram_arbiter: owns the write port of the VGA text RAM. It round-robins
// writes between the keyboard editor (kb) and the shell output writer (term),
// and optionally runs a bulk-clear sequencer that fills every cell with FILL.
// The clear sequencer is compiled in only when TEXT_ARB_CLEAR_EN is defined.
// Without it, the block is a plain two-way arbiter and clr_busy/clr_done stay 0.
// dbg_state exposes the FSM state (0 = IDLE, 1 = CLEAR) for observation.
module text_ram_arbiter #(
   parameter int            DEPTH = 4200,
   parameter int            AW    = 13,
   parameter int            DW    = 8,
   parameter logic [DW-1:0] FILL  = {DW{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   text_ram_arbiter_if.slave bus,
   output logic [0:0]       dbg_state
);

`ifdef TEXT_ARB_CLEAR_EN
   localparam logic CLR_EN = 1'b1;
`else
   localparam logic CLR_EN = 1'b0;
`endif

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   // last_grant encoding: who was served most recently
   localparam logic LG_KB   = 1'b0;
   localparam logic LG_TERM = 1'b1;

   // One extra bit so the counter can reach DEPTH even when DEPTH == 2^AW
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   logic [0:0]    state;
   logic          last_grant;
   logic [AW:0]   clr_cnt;
   logic          kb_ack_q;
   logic          term_ack_q;
   logic          wr_err_q;
   logic          clr_busy_q;
   logic          clr_done_q;
   logic          ram_we_q;
   logic [AW-1:0] ram_addr_q;
   logic [DW-1:0] ram_wdata_q;

   logic          kb_elig;
   logic          term_elig;
   logic          grant_kb;
   logic          grant_term;
   logic          grant_any;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_data;
   logic          sel_in_range;
   logic          start_clr;
   logic          clr_end;

   // Pick the winner for this edge and decode the clear start/end conditions
   always_comb begin
      kb_elig      = bus.kb_req && !kb_ack_q;
      term_elig    = bus.term_req && !term_ack_q;
      grant_kb     = kb_elig && (!term_elig || (last_grant == LG_TERM));
      grant_term   = term_elig && !grant_kb;
      grant_any    = grant_kb || grant_term;
      sel_addr     = grant_term ? bus.term_addr : bus.kb_addr;
      sel_data     = grant_term ? bus.term_data : bus.kb_data;
      sel_in_range = {1'b0, sel_addr} < DEPTH_W;
      start_clr    = CLR_EN && bus.clr_start && (state == ST_IDLE);
      clr_end      = (state == ST_CLEAR) && (clr_cnt == DEPTH_W);
   end

   // FSM, clear counter, grant bookkeeping and registered RAM write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         last_grant  <= LG_TERM;
         clr_cnt     <= '0;
         kb_ack_q    <= 1'b0;
         term_ack_q  <= 1'b0;
         wr_err_q    <= 1'b0;
         clr_busy_q  <= 1'b0;
         clr_done_q  <= 1'b0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_wdata_q <= '0;
      end else begin
         kb_ack_q   <= 1'b0;
         term_ack_q <= 1'b0;
         wr_err_q   <= 1'b0;
         clr_done_q <= 1'b0;
         ram_we_q   <= 1'b0;
         if (start_clr) begin
            // Clear wins over any pending request; the first fill write goes out next cycle
            state       <= ST_CLEAR;
            clr_busy_q  <= 1'b1;
            ram_we_q    <= 1'b1;
            ram_addr_q  <= '0;
            ram_wdata_q <= FILL;
            clr_cnt     <= {{AW{1'b0}}, 1'b1};
         end else if ((state == ST_CLEAR) && !clr_end) begin
            ram_we_q    <= 1'b1;
            ram_addr_q  <= clr_cnt[AW-1:0];
            ram_wdata_q <= FILL;
            clr_cnt     <= clr_cnt + 1'b1;
         end else begin
            if (clr_end) begin
               state      <= ST_IDLE;
               clr_busy_q <= 1'b0;
               clr_done_q <= 1'b1;
               clr_cnt    <= '0;
            end
            // Arbitration also runs on the clear-end edge, so an ack can meet clr_done
            if (grant_any) begin
               ram_addr_q  <= sel_addr;
               ram_wdata_q <= sel_data;
               ram_we_q    <= sel_in_range;
               wr_err_q    <= !sel_in_range;
               kb_ack_q    <= grant_kb;
               term_ack_q  <= grant_term;
               last_grant  <= grant_term ? LG_TERM : LG_KB;
            end
         end
      end
   end

   assign bus.kb_ack    = kb_ack_q;
   assign bus.term_ack  = term_ack_q;
   assign bus.wr_err    = wr_err_q;
   assign bus.clr_busy  = clr_busy_q;
   assign bus.clr_done  = clr_done_q;
   assign bus.ram_we    = ram_we_q;
   assign bus.ram_addr  = ram_addr_q;
   assign bus.ram_wdata = ram_wdata_q;
   assign dbg_state     = state;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// tb_text_ram_arbiter: directed bench for text_ram_arbiter. The clear and
// mid-clear reset steps run when TEXT_ARB_CLEAR_EN is defined. Otherwise the
// bench checks that clr_start is ignored.
module tb_text_ram_arbiter;
   localparam int DEPTH = 4200;
   localparam int AW    = 13;
   localparam int DW    = 8;

   logic       clk;
   logic       rst_n;
   logic [0:0] dbg_state;
   int         n_checks;
   int         n_fail;

   text_ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   text_ram_arbiter #(
      .DEPTH(DEPTH), .AW(AW), .DW(DW), .FILL(8'h00)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .dbg_state (dbg_state)
   );

   // clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // one cycle; outputs are sampled 1 ns after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // compare the whole output bundle against one expected vector
   task automatic chk_out(input string tag, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata, input logic kb_ack, input logic term_ack,
                          input logic err, input logic busy, input logic done);
      chk({tag, ".ram_we"},    32'(bus.ram_we),    32'(we));
      chk({tag, ".ram_addr"},  32'(bus.ram_addr),  32'(addr));
      chk({tag, ".ram_wdata"}, 32'(bus.ram_wdata), 32'(wdata));
      chk({tag, ".kb_ack"},    32'(bus.kb_ack),    32'(kb_ack));
      chk({tag, ".term_ack"},  32'(bus.term_ack),  32'(term_ack));
      chk({tag, ".wr_err"},    32'(bus.wr_err),    32'(err));
      chk({tag, ".clr_busy"},  32'(bus.clr_busy),  32'(busy));
      chk({tag, ".clr_done"},  32'(bus.clr_done),  32'(done));
   endtask

   // driver tasks
   task automatic drive_kb(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.kb_req  = req;
      bus.kb_addr = addr;
      bus.kb_data = data;
   endtask

   task automatic drive_term(input logic req, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      bus.term_req  = req;
      bus.term_addr = addr;
      bus.term_data = data;
   endtask

   // scoreboard of expected write addresses for the contention run
   logic [AW-1:0] exp_q[$];

   initial begin
      logic [AW-1:0] exp_addr;
      int            bad;
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      bus.clr_start = 1'b0;
      drive_kb(1'b0, '0, '0);
      drive_term(1'b0, '0, '0);

      // reset state
      repeat (2) tick();
      chk_out("reset", 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.state", 32'(dbg_state), 32'd0);
      rst_n = 1'b1;
      tick();

      // uncontended kb write, req still held in the ack cycle
      drive_kb(1'b1, 13'd9, 8'h61);
      tick();
      chk_out("kb_single", 1'b1, 13'd9, 8'h61, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("kb_no_double", 1'b0, 13'd9, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_kb(1'b0, 13'd9, 8'h61);
      tick();

      // out-of-range term address: ack plus wr_err, no write
      drive_term(1'b1, 13'd4200, 8'h55);
      tick();
      chk_out("term_oor", 1'b0, 13'd4200, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      drive_term(1'b0, 13'd4200, 8'h55);
      tick();
      chk_out("term_oor_after", 1'b0, 13'd4200, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // contention: term was served last, so kb leads, then strict alternation
      drive_kb(1'b1, 13'd100, 8'h41);
      drive_term(1'b1, 13'd200, 8'h42);
      for (int i = 0; i < 8; i++) exp_q.push_back((i % 2 == 0) ? 13'd100 : 13'd200);
      for (int i = 0; i < 8; i++) begin
         tick();
         exp_addr = exp_q.pop_front();
         chk_out($sformatf("contend%0d", i), 1'b1, exp_addr,
                 (exp_addr == 13'd100) ? 8'h41 : 8'h42,
                 exp_addr == 13'd100, exp_addr == 13'd200, 1'b0, 1'b0, 1'b0);
      end
      drive_kb(1'b0, 13'd100, 8'h41);
      drive_term(1'b0, 13'd200, 8'h42);
      tick();
      chk_out("contend_end", 1'b0, 13'd200, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef TEXT_ARB_CLEAR_EN
      // clear with kb pending: clear wins, kb is acked in the clr_done cycle
      drive_kb(1'b1, 13'd7, 8'h4b);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      chk_out("clr_first", 1'b1, 13'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("clr_first.state", 32'(dbg_state), 32'd1);
      bad = 0;
      for (int k = 1; k < DEPTH; k++) begin
         bus.clr_start = (k == 10);   // restart request while busy must be ignored
         tick();
         if (bus.ram_we !== 1'b1 || bus.ram_addr !== AW'(k) || bus.ram_wdata !== 8'h00 ||
             bus.clr_busy !== 1'b1 || bus.clr_done !== 1'b0 || bus.kb_ack !== 1'b0 ||
             bus.term_ack !== 1'b0 || bus.wr_err !== 1'b0) bad++;
      end
      bus.clr_start = 1'b0;
      chk("clr_seq_bad_cycles", 32'(bad), 32'd0);
      tick();
      chk_out("clr_done", 1'b1, 13'd7, 8'h4b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("clr_done.state", 32'(dbg_state), 32'd0);
      drive_kb(1'b0, 13'd7, 8'h4b);
      tick();
      chk_out("clr_after", 1'b0, 13'd7, 8'h4b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // reset mid-clear at address 1000
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      repeat (1000) tick();
      chk("midclr.addr", 32'(bus.ram_addr), 32'd1000);
      rst_n = 1'b0;
      #1;
      chk_out("midclr_rst", 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("midclr_rst.state", 32'(dbg_state), 32'd0);
`else
      // clr_start is ignored: pending kb acked normally, no clear activity
      drive_kb(1'b1, 13'd7, 8'h4b);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      chk_out("noclr_kb", 1'b1, 13'd7, 8'h4b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      drive_kb(1'b0, 13'd7, 8'h4b);
      bus.clr_start = 1'b1;
      tick();
      bus.clr_start = 1'b0;
      bad = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.ram_we !== 1'b0 || bus.clr_busy !== 1'b0 || bus.clr_done !== 1'b0) bad++;
      end
      chk("noclr_idle_bad_cycles", 32'(bad), 32'd0);
      chk("noclr.state", 32'(dbg_state), 32'd0);

      // asynchronous reset in the middle of an ack cycle
      drive_kb(1'b1, 13'd33, 8'h5a);
      tick();
      chk("midwr.kb_ack", 32'(bus.kb_ack), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_out("midwr_rst", 1'b0, 13'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

      // after reset: quiet outputs, then kb wins the first tie again
      drive_kb(1'b0, '0, '0);
      drive_term(1'b0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (bus.ram_we !== 1'b0 || bus.clr_done !== 1'b0 || bus.clr_busy !== 1'b0) bad++;
      end
      chk("post_rst_quiet_bad_cycles", 32'(bad), 32'd0);
      drive_kb(1'b1, 13'd300, 8'h31);
      drive_term(1'b1, 13'd301, 8'h32);
      tick();
      chk_out("post_rst_tie", 1'b1, 13'd300, 8'h31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk_out("post_rst_alt", 1'b1, 13'd301, 8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive_kb(1'b0, 13'd300, 8'h31);
      drive_term(1'b0, 13'd301, 8'h32);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
